// File: rtl/nlin_f_out_buf.sv
// Elastic FWFT output buffer behind the non-linear units: circular RAM plus an
// output register, with credit-based clock-enable generation and word/frame counters.
package nlin_f_out_buf_pkg;
  typedef struct packed {
    logic [15:0] data_word;
    logic [1:0]  data_type;
    logic        data_val;
    logic        data_last;
  } pipe_data_t;

  localparam int          C_PIPE_DATA_WDT     = $bits(pipe_data_t);
  localparam logic [15:0] C_PIPE_DATA_RST_VAL = 16'h0000;
endpackage

module nlin_f_out_buf
  import nlin_f_out_buf_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_WDT    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ext_en,
  output logic               pipe_clk_en,
  input  pipe_data_t         nlin_res,
  output pipe_data_t         m_data,
  output logic               m_valid,
  input  logic               m_ready,
  output logic [CNT_WDT-1:0] word_cnt,
  output logic [CNT_WDT-1:0] frame_cnt,
  output logic               empty,
  output logic               ovf_err
);
  localparam int             AW       = $clog2(FIFO_DEPTH);
  localparam int             RAM_D    = FIFO_DEPTH - 1;
  localparam logic [AW-1:0]  PTR_LAST = AW'(RAM_D - 1);
  localparam logic [AW:0]    OCC_FULL = (AW+1)'(FIFO_DEPTH);

  pipe_data_t    mem [RAM_D];
  pipe_data_t    out_q;
  logic          out_vld, credit_q;
  logic [AW-1:0] wr_ptr, rd_ptr, ram_cnt;
  logic [AW:0]   occ, occ_next;
  logic          push_req, full, push, pop, out_free, ram_rd, ram_wr, bypass;

  assign pipe_clk_en = credit_q & ext_en;
  assign m_valid     = out_vld;

  always_comb begin
    m_data          = out_q;
    m_data.data_val = out_vld;
  end

  // out_vld==0 implies the RAM is empty, so occ never exceeds FIFO_DEPTH
  assign occ      = {1'b0, ram_cnt} + (AW+1)'(out_vld);
  assign full     = (occ == OCC_FULL);
  assign push_req = pipe_clk_en & nlin_res.data_val;
  assign push     = push_req & ~full;
  assign pop      = out_vld & m_ready;
  assign out_free = ~out_vld | pop;
  assign ram_rd   = out_free & (ram_cnt != '0);
  assign bypass   = push & out_free & (ram_cnt == '0);
  assign ram_wr   = push & ~bypass;
  assign occ_next = occ + (AW+1)'(push) - (AW+1)'(pop);

  function automatic logic [AW-1:0] next_ptr(input logic [AW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + AW'(1);
  endfunction

  // RAM contents are don't-care after reset; only pointers/count are cleared
  always_ff @(posedge clk) begin
    if (ram_wr) mem[wr_ptr] <= nlin_res;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= '{data_word: C_PIPE_DATA_RST_VAL, default: '0};
      out_vld   <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      ram_cnt   <= '0;
      credit_q  <= 1'b1;
      empty     <= 1'b1;
      ovf_err   <= 1'b0;
      word_cnt  <= '0;
      frame_cnt <= '0;
    end else begin
      if (ram_rd)      out_q <= mem[rd_ptr];
      else if (bypass) out_q <= nlin_res;
      if (out_free)    out_vld <= ram_rd | bypass;
      if (ram_rd)      rd_ptr <= next_ptr(rd_ptr);
      if (ram_wr)      wr_ptr <= next_ptr(wr_ptr);
      ram_cnt  <= ram_cnt + AW'(ram_wr) - AW'(ram_rd);
      credit_q <= (occ_next < OCC_FULL);
      empty    <= (occ_next == '0);
      if (push_req & full) ovf_err <= 1'b1;
      if (pop) begin
        if (out_q.data_last) begin
          word_cnt  <= '0;
          frame_cnt <= frame_cnt + CNT_WDT'(1);
        end else begin
          word_cnt  <= word_cnt + CNT_WDT'(1);
        end
      end
    end
  end
endmodule

// File: tb/tb_nlin_f_out_buf.sv
// Directed bench for nlin_f_out_buf: hand-computed vector table plus
// queue-model sequences for stall, wrap, random back-pressure and reset.
module tb_nlin_f_out_buf;
  import nlin_f_out_buf_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n, ext_en, m_ready;
  logic        pipe_clk_en, m_valid, empty, ovf_err;
  pipe_data_t  nlin_res, m_data;
  logic [15:0] word_cnt, frame_cnt;

  int tests = 0;
  int fails = 0;

  nlin_f_out_buf #(.FIFO_DEPTH(16), .CNT_WDT(16)) dut (
    .clk(clk), .rst_n(rst_n), .ext_en(ext_en), .pipe_clk_en(pipe_clk_en),
    .nlin_res(nlin_res), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .word_cnt(word_cnt), .frame_cnt(frame_cnt), .empty(empty), .ovf_err(ovf_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          en, val, last;
    logic [15:0] word;
    bit          rdy;
    bit          exp_vld;
    logic [15:0] exp_word;
    bit          exp_pce;
    logic [15:0] exp_wc, exp_fc;
  } vec_t;

  vec_t tbl [14];

  // reference model state
  pipe_data_t  q [$];
  bit          credit_m;
  logic [15:0] wc_m, fc_m;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    q.delete();
    credit_m = 1'b1;
    wc_m = '0;
    fc_m = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; ext_en = 1'b1; m_ready = 1'b0; nlin_res = '0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One cycle: drive, compare against the model mid-cycle, then advance the model.
  task automatic cyc(input bit en, input bit val, input bit last, input logic [1:0] typ,
                     input logic [15:0] word, input bit rdy);
    pipe_data_t f;
    bit push, pop;
    ext_en = en; m_ready = rdy;
    nlin_res = '{data_word: word, data_type: typ, data_val: val, data_last: last};
    @(negedge clk);
    check("pce", pipe_clk_en, credit_m & en);
    check("vld", m_valid, q.size() != 0);
    if (q.size() != 0)
      check("data", {m_data.data_word, m_data.data_type, m_data.data_last},
                    {q[0].data_word, q[0].data_type, q[0].data_last});
    check("empty", empty, q.size() == 0);
    check("cnt", {word_cnt, frame_cnt}, {wc_m, fc_m});
    check("ovf", ovf_err, 1'b0);
    push = credit_m & en & val;
    pop  = (q.size() != 0) && rdy;
    if (pop) begin
      f = q.pop_front();
      if (f.data_last) begin wc_m = '0; fc_m = fc_m + 16'd1; end
      else wc_m = wc_m + 16'd1;
    end
    if (push) q.push_back(nlin_res);
    credit_m = (q.size() < 16);
    @(posedge clk); #1;
  endtask

  initial begin
    for (int k = 0; k < 8; k++)
      tbl[k] = '{1'b1, 1'b1, k == 7, 16'(k + 1), 1'b1, 1'b1, 16'(k + 1), 1'b1, 16'(k), 16'd0};
    tbl[8]  = '{1'b1, 1'b0, 1'b0, 16'hBAD0, 1'b1, 1'b0, 16'h0000, 1'b1, 16'd0, 16'd1};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'h0055, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd0, 16'd1};
    tbl[10] = '{1'b1, 1'b1, 1'b0, 16'h000A, 1'b0, 1'b1, 16'h000A, 1'b1, 16'd0, 16'd1};
    tbl[11] = '{1'b1, 1'b1, 1'b0, 16'h000B, 1'b0, 1'b1, 16'h000A, 1'b1, 16'd0, 16'd1};
    tbl[12] = '{1'b0, 1'b1, 1'b0, 16'h00CC, 1'b1, 1'b1, 16'h000B, 1'b0, 16'd1, 16'd1};
    tbl[13] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 16'd2, 16'd1};

    // reset state
    rst_n = 1'b0; ext_en = 1'b1; m_ready = 1'b0; nlin_res = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vld", m_valid, 1'b0);
    check("rst_data", {m_data.data_word, m_data.data_type, m_data.data_val, m_data.data_last},
                      {C_PIPE_DATA_RST_VAL, 4'h0});
    check("rst_empty", empty, 1'b1);
    check("rst_ovf", ovf_err, 1'b0);
    check("rst_cnt", {word_cnt, frame_cnt}, 32'h0);
    check("rst_pce", pipe_clk_en, 1'b1);
    rst_n = 1'b1;

    // vector table: pass-through frame, invalid words, ext_en gating, handshake hold
    for (int i = 0; i < 14; i++) begin
      ext_en = tbl[i].en; m_ready = tbl[i].rdy;
      nlin_res = '{data_word: tbl[i].word, data_type: 2'b00, data_val: tbl[i].val,
                   data_last: tbl[i].last};
      @(posedge clk); #1;
      check($sformatf("tbl%0d_vld", i), m_valid, tbl[i].exp_vld);
      if (tbl[i].exp_vld) check($sformatf("tbl%0d_word", i), m_data.data_word, tbl[i].exp_word);
      check($sformatf("tbl%0d_pce", i), pipe_clk_en, tbl[i].exp_pce);
      check($sformatf("tbl%0d_wc", i), word_cnt, tbl[i].exp_wc);
      check($sformatf("tbl%0d_fc", i), frame_cnt, tbl[i].exp_fc);
    end

    // fill and stall, then single pop at full with a push following
    do_reset();
    for (int n = 0; n < 20; n++) cyc(1'b1, 1'b1, 1'b0, 2'(n), 16'h0100 + 16'(n), 1'b0);
    check("stall_pce", pipe_clk_en, 1'b0);
    check("stall_ovf", ovf_err, 1'b0);
    check("stall_head", m_data.data_word, 16'h0100);
    cyc(1'b1, 1'b1, 1'b0, 2'd1, 16'h01F0, 1'b1);
    check("credit_back", pipe_clk_en, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 2'd2, 16'h01F1, 1'b0);
    check("refull_pce", pipe_clk_en, 1'b0);

    // random back-pressure with scoreboard
    for (int n = 0; n < 1000; n++)
      cyc($urandom_range(0, 9) != 0, 1'($urandom), $urandom_range(0, 4) == 0,
          2'($urandom), 16'($urandom), 1'($urandom));
    repeat (20) cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    check("rand_drained", empty, 1'b1);

    // pointer wrap with toggling ready
    for (int n = 0; n < 100; n++)
      cyc(1'b1, 1'b1, (n % 7) == 6, 2'(n), 16'h2000 + 16'(n), n[0]);
    repeat (60) cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    check("wrap_drained", empty, 1'b1);

    // reset mid-frame
    do_reset();
    for (int n = 0; n < 5; n++) cyc(1'b1, 1'b1, 1'b0, 2'd3, 16'h3000 + 16'(n), 1'b0);
    rst_n = 1'b0; ext_en = 1'b1; m_ready = 1'b0;
    nlin_res = '{data_word: 16'hDEAD, data_type: 2'b01, data_val: 1'b1, data_last: 1'b0};
    @(posedge clk); #1;
    check("mrst_vld", m_valid, 1'b0);
    check("mrst_empty", empty, 1'b1);
    check("mrst_cnt", {word_cnt, frame_cnt}, 32'h0);
    check("mrst_pce", pipe_clk_en, 1'b1);
    rst_n = 1'b1;
    model_reset();
    for (int n = 0; n < 3; n++) cyc(1'b1, 1'b1, n == 2, 2'd2, 16'h4000 + 16'(n), 1'b1);
    repeat (4) cyc(1'b1, 1'b0, 1'b0, 2'd0, 16'h0, 1'b1);
    check("mrst_fc", frame_cnt, 16'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
